mixer_scheduler: RTL

MIXER_SCHEDULER -- requirements
Module: mixer_scheduler

---
 rtl/mixer_scheduler_if.sv | 33 +++
 rtl/mixer_scheduler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mixer_scheduler_if.sv
// Stream bundle for the mixer: per-channel sample inputs
// and the single mixed output, each with valid/ready.
interface mixer_scheduler_if #(
  parameter int AUDIO_WIDTH_P    = 24,
  parameter int NR_OF_CHANNELS_P = 4
) ();

  logic [NR_OF_CHANNELS_P-1:0][AUDIO_WIDTH_P-1:0] channel_data;
  logic [NR_OF_CHANNELS_P-1:0] channel_valid;
  logic [NR_OF_CHANNELS_P-1:0] channel_ready;
  logic [AUDIO_WIDTH_P-1:0]    mixed_data;
  logic                        mixed_valid;
  logic                        mixed_ready;

  modport master (
    output channel_data,
    output channel_valid,
    input  channel_ready,
    input  mixed_data,
    input  mixed_valid,
    output mixed_ready
  );

  modport slave (
    input  channel_data,
    input  channel_valid,
    output channel_ready,
    output mixed_data,
    output mixed_valid,
    input  mixed_ready
  );

endinterface

// File: rtl/mixer_scheduler.sv
// Multi-channel gain mixer: one shared multiplier walks the
// channels serially, then applies master gain with saturation.
module mixer_scheduler #(
  parameter int AUDIO_WIDTH_P    = 24,
  parameter int GAIN_WIDTH_P     = 16,
  parameter int NR_OF_CHANNELS_P = 4,
  parameter int Q_BITS_P         = 8
) (
  input  logic clk,
  input  logic rst,
  mixer_scheduler_if.slave bus,
  input  logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0] cr_channel_gain,
  input  logic [GAIN_WIDTH_P-1:0]     cr_output_gain,
  input  logic [NR_OF_CHANNELS_P-1:0] cr_channel_enable,
  output logic [15:0]                 sr_clip_count,
  output logic                        sr_busy
);

  localparam int N      = NR_OF_CHANNELS_P;
  localparam int AW     = AUDIO_WIDTH_P;
  localparam int GW     = GAIN_WIDTH_P;
  localparam int IDX_W  = $clog2(N);
  localparam int ACC_W  = AW + GW + $clog2(N) + 1;
  localparam int PROD_W = ACC_W + GW + 1;

  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(PROD_W-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    {{(PROD_W-AW+1){1'b1}}, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, MAC, GAIN, OUT
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]             pending;
  logic signed [AW-1:0]     capture [N];
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;
  logic [N-1:0]             mask;
  logic [AW-1:0]            mixed_q;

  logic                     start;
  logic                     mac_last;
  logic signed [PROD_W-1:0] mul_a;
  logic signed [PROD_W-1:0] mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] scaled;
  logic                     clip_hi;
  logic                     clip_lo;
  logic [AW-1:0]            sat_val;

  assign start = (|cr_channel_enable) &&
    ((pending & cr_channel_enable) == cr_channel_enable);
  assign mac_last = (idx == IDX_W'(N-1));

  assign bus.channel_ready = ~pending;
  assign bus.mixed_data    = mixed_q;

  // Shared multiplier: channel term during MAC, master gain in GAIN.
  always_comb begin
    mul_a = PROD_W'(capture[idx]);
    mul_b = $signed(PROD_W'(cr_channel_gain[idx]));
    if (state == GAIN) begin
      mul_a = PROD_W'(acc);
      mul_b = $signed(PROD_W'(cr_output_gain));
    end
    prod    = mul_a * mul_b;
    scaled  = prod >>> Q_BITS_P;
    clip_hi = scaled > SAT_MAX;
    clip_lo = scaled < SAT_MIN;
    sat_val = scaled[AW-1:0];
    if (clip_hi) sat_val = {1'b0, {(AW-1){1'b1}}};
    if (clip_lo) sat_val = {1'b1, {(AW-1){1'b0}}};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = MAC;
      MAC:  if (mac_last) state_nxt = GAIN;
      GAIN: state_nxt = OUT;
      OUT:  if (bus.mixed_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from state.
  always_comb begin
    bus.mixed_valid = (state == OUT);
    sr_busy         = (state != IDLE);
  end

  // Capture slots, accumulator, output register and clip counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= '0;
      acc           <= '0;
      idx           <= '0;
      mask          <= '0;
      mixed_q       <= '0;
      sr_clip_count <= '0;
      for (int i = 0; i < N; i++) capture[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.channel_valid[i] && !pending[i]) begin
          capture[i] <= bus.channel_data[i];
          pending[i] <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            mask <= cr_channel_enable;
            acc  <= '0;
            idx  <= '0;
          end
        end
        MAC: begin
          if (mask[idx]) begin
            acc          <= acc + $signed(scaled[ACC_W-1:0]);
            pending[idx] <= 1'b0;
          end
          idx <= idx + IDX_W'(1);
        end
        GAIN: begin
          mixed_q <= sat_val;
          if ((clip_hi || clip_lo) && sr_clip_count != 16'hFFFF)
            sr_clip_count <= sr_clip_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
